posit_prec_scheduler: RTL

- Front-end sequencer for the runtime precision-scalable posit datapath.
- Accepts packed operand pairs (1x32b, 2x16b or 4x8b lanes per 32-bit word) and issues them to the datapath.
- Owns the datapath precision configuration: a precision change drains in-flight work, reconfigures, waits a settle period, then resumes.
- Buffers datapath results in a credit-protected FIFO, each entry tagged with its precision, so downstream backpressure never drops a result.

---
 rtl/posit_prec_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/posit_prec_scheduler.sv
// Operand issue / precision-reconfiguration sequencer with a credit-protected result FIFO.
// Optional perf counters are compiled in with `define POSIT_SCHED_PERF_EN.
module posit_prec_scheduler #(
  parameter int FULL_L     = 32,
  parameter int RES_DEPTH  = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_prec,
  output logic              cfg_ready,
  input  logic              in_valid,
  input  logic [FULL_L-1:0] in_a,
  input  logic [FULL_L-1:0] in_b,
  output logic              in_ready,
  output logic              dp_valid,
  output logic [FULL_L-1:0] dp_a,
  output logic [FULL_L-1:0] dp_b,
  output logic [1:0]        dp_prec,
  input  logic              dp_res_valid,
  input  logic [FULL_L-1:0] dp_res,
  output logic              out_valid,
  output logic [FULL_L-1:0] out_data,
  output logic [1:0]        out_prec,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        err
`ifdef POSIT_SCHED_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_issue,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_RECFG} state_t;

  state_t              r_state;
  logic [1:0]          r_pend_prec;
  logic [1:0]          r_dp_prec;
  logic [3:0]          r_settle;
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_cnt;
  logic                r_out_valid;
  logic                r_dp_valid;
  logic [FULL_L-1:0]   r_dp_a;
  logic [FULL_L-1:0]   r_dp_b;
  logic [1:0]          r_err;
  logic [FULL_L+1:0]   r_mem [RES_DEPTH];

  logic                w_credit_ok;
  logic                w_in_ready;
  logic                w_cfg_ready;
  logic                w_issue;
  logic                w_cfg_hs;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_wr_idx;
  logic [CW-1:0]       w_cnt_nxt;

  // Credit covers both in-flight and buffered results so the FIFO can never overflow.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_cnt}) < (CW+1)'(RES_DEPTH);
  assign w_cfg_ready = (r_state == S_RUN);
  assign w_in_ready  = (r_state == S_RUN) && !cfg_valid && w_credit_ok;
  assign w_issue     = in_valid && w_in_ready;
  assign w_cfg_hs    = cfg_valid && w_cfg_ready;
  assign w_push      = dp_res_valid && (r_inflight != '0);
  assign w_pop       = r_out_valid && out_ready;
  assign w_wr_idx    = r_cnt - CW'(w_pop);
  assign w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);

  assign cfg_ready = w_cfg_ready;
  assign in_ready  = w_in_ready;
  assign busy      = (r_state != S_RUN) || (r_inflight != '0);
  assign dp_valid  = r_dp_valid;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_prec   = r_dp_prec;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[0][FULL_L-1:0];
  assign out_prec  = r_mem[0][FULL_L+1:FULL_L];
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_pend_prec <= 2'd0;
      r_dp_prec   <= 2'd0;
      r_settle    <= 4'd0;
      r_inflight  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_err       <= 2'b00;
    end else begin
      r_dp_valid <= w_issue;
      if (w_issue) begin
        r_dp_a <= in_a;
        r_dp_b <= in_b;
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
      if (w_cfg_hs && cfg_prec == 2'd3)         r_err[0] <= 1'b1;
      if (dp_res_valid && r_inflight == '0)     r_err[1] <= 1'b1;
      case (r_state)
        S_RUN: begin
          if (w_cfg_hs && cfg_prec != 2'd3 && cfg_prec != r_dp_prec) begin
            r_pend_prec <= cfg_prec;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_inflight == '0) begin
            r_state   <= S_RECFG;
            r_dp_prec <= r_pend_prec;
            r_settle  <= 4'(SETTLE_CYC - 1);
          end
        end
        S_RECFG: begin
          if (r_settle == 4'd0) r_state  <= S_RUN;
          else                  r_settle <= r_settle - 4'd1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Shift-register FIFO: entry 0 is the registered head driving the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < RES_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      if (w_pop) begin
        for (int i = 0; i < RES_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      for (int i = 0; i < RES_DEPTH; i++) begin
        if (w_push && w_wr_idx == CW'(i)) r_mem[i] <= {r_dp_prec, dp_res};
      end
    end
  end

`ifdef POSIT_SCHED_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue && !(&r_perf_issue))                  r_perf_issue <= r_perf_issue + 32'd1;
      if (in_valid && !w_in_ready && !(&r_perf_stall))  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_stall = r_perf_stall;
`endif

endmodule
